// File: rtl/execute_stage_pkg.sv
// Shared encodings for the EX stage: ALU operations, forwarding selects and
// writeback source selects.
package execute_stage_pkg;

  typedef enum logic [2:0] {
    ALU_ADD = 3'b000,
    ALU_SUB = 3'b001,
    ALU_AND = 3'b010,
    ALU_OR  = 3'b011,
    ALU_XOR = 3'b100,
    ALU_SLL = 3'b101,
    ALU_SRL = 3'b110,
    ALU_SLT = 3'b111
  } aluOp_e;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

  // Consumed by the WB stage; the EX stage only carries it through.
  localparam logic [1:0] WB_ALU = 2'b00;
  localparam logic [1:0] WB_MEM = 2'b01;
  localparam logic [1:0] WB_PC4 = 2'b10;

endpackage

// File: rtl/execute_stage_alu.sv
// Combinational 32-bit ALU. Results wrap modulo 2^32 and no flags are produced.
module execute_stage_alu
  import execute_stage_pkg::*;
(
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic [2:0]  ALUsel,
  output logic [31:0] result
);

  always_comb begin
    result = 32'd0;
    case (ALUsel)
      ALU_ADD: result = A + B;
      ALU_SUB: result = A - B;
      ALU_AND: result = A & B;
      ALU_OR:  result = A | B;
      ALU_XOR: result = A ^ B;
      ALU_SLL: result = A << B[4:0];
      ALU_SRL: result = A >> B[4:0];
      ALU_SLT: result = {31'd0, $signed(A) < $signed(B)};
      default: result = 32'd0;
    endcase
  end

endmodule

// File: rtl/execute_stage.sv
// EX stage: operand forwarding, operand select, ALU, and the EX/MEM register.
// rst_n is active-high despite its name.
module execute_stage
  import execute_stage_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        regwriteE,
  input  logic        memrwE,
  input  logic [1:0]  wbselE,
  input  logic [2:0]  ALUselE,
  input  logic        aselE,
  input  logic        bselE,
  input  logic [1:0]  forwardAE,
  input  logic [1:0]  forwardBE,
  input  logic [31:0] resultW,
  input  logic [31:0] rd1E,
  input  logic [31:0] rd2E,
  input  logic [31:0] imm_exE,
  input  logic [31:0] pcE,
  input  logic [31:0] pc4E,
  input  logic [4:0]  rs1E,
  input  logic [4:0]  rs2E,
  input  logic [4:0]  rdE,
  output logic        regwriteM,
  output logic        memrwM,
  output logic [1:0]  wbselM,
  output logic [31:0] pc4M,
  output logic [4:0]  rdM,
  output logic [31:0] ALUresM,
  output logic [31:0] data_writeM
);

  logic [31:0] srcA_fwd;
  logic [31:0] srcB_fwd;
  logic [31:0] opA;
  logic [31:0] opB;
  logic [31:0] aluRes;
  logic        unusedIdx;

  // Source indices only matter to the hazard unit.
  assign unusedIdx = ^{rs1E, rs2E};

  // FWD_MEM reads the registered result, so there is no loop through the ALU.
  always_comb begin
    srcA_fwd = rd1E;
    case (forwardAE)
      FWD_WB:  srcA_fwd = resultW;
      FWD_MEM: srcA_fwd = ALUresM;
      default: srcA_fwd = rd1E;
    endcase
  end

  always_comb begin
    srcB_fwd = rd2E;
    case (forwardBE)
      FWD_WB:  srcB_fwd = resultW;
      FWD_MEM: srcB_fwd = ALUresM;
      default: srcB_fwd = rd2E;
    endcase
  end

  assign opA = aselE ? pcE : srcA_fwd;
  assign opB = bselE ? imm_exE : srcB_fwd;

  execute_stage_alu uAlu (
    .A      (opA),
    .B      (opB),
    .ALUsel (ALUselE),
    .result (aluRes)
  );

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      regwriteM   <= 1'b0;
      memrwM      <= 1'b0;
      wbselM      <= 2'b00;
      pc4M        <= 32'd0;
      rdM         <= 5'd0;
      ALUresM     <= 32'd0;
      data_writeM <= 32'd0;
    end else begin
      regwriteM   <= regwriteE;
      memrwM      <= memrwE;
      wbselM      <= wbselE;
      pc4M        <= pc4E;
      rdM         <= rdE;
      ALUresM     <= aluRes;
      // Store data is taken after forwarding but before the immediate mux.
      data_writeM <= srcB_fwd;
    end
  end

endmodule

// File: tb/tb_execute_stage.sv
// Directed, table-driven bench for execute_stage with hand-computed results
// plus reset/forwarding sequences.
module tb_execute_stage;

  logic        clk;
  logic        rst_n;
  logic        regwriteE, memrwE, aselE, bselE;
  logic [1:0]  wbselE, forwardAE, forwardBE;
  logic [2:0]  ALUselE;
  logic [31:0] resultW, rd1E, rd2E, imm_exE, pcE, pc4E;
  logic [4:0]  rs1E, rs2E, rdE;
  logic        regwriteM, memrwM;
  logic [1:0]  wbselM;
  logic [31:0] pc4M, ALUresM, data_writeM;
  logic [4:0]  rdM;

  int errors = 0;
  int checks = 0;

  execute_stage dut (
    .clk(clk), .rst_n(rst_n),
    .regwriteE(regwriteE), .memrwE(memrwE), .wbselE(wbselE), .ALUselE(ALUselE),
    .aselE(aselE), .bselE(bselE), .forwardAE(forwardAE), .forwardBE(forwardBE),
    .resultW(resultW), .rd1E(rd1E), .rd2E(rd2E), .imm_exE(imm_exE),
    .pcE(pcE), .pc4E(pc4E), .rs1E(rs1E), .rs2E(rs2E), .rdE(rdE),
    .regwriteM(regwriteM), .memrwM(memrwM), .wbselM(wbselM), .pc4M(pc4M),
    .rdM(rdM), .ALUresM(ALUresM), .data_writeM(data_writeM)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  op;
    logic [1:0]  fa, fb;
    logic        asel, bsel;
    logic [31:0] rd1, rd2, resW, pc, imm;
    logic [31:0] expAlu, expData;
  } vec_t;

  vec_t vecs[15];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chkAllZero(input string tag);
    chk({tag, ".regwriteM"}, {31'd0, regwriteM}, 32'd0);
    chk({tag, ".memrwM"}, {31'd0, memrwM}, 32'd0);
    chk({tag, ".wbselM"}, {30'd0, wbselM}, 32'd0);
    chk({tag, ".pc4M"}, pc4M, 32'd0);
    chk({tag, ".rdM"}, {27'd0, rdM}, 32'd0);
    chk({tag, ".ALUresM"}, ALUresM, 32'd0);
    chk({tag, ".data_writeM"}, data_writeM, 32'd0);
  endtask

  function automatic vec_t mk(input logic [2:0] op, input logic [1:0] fa, input logic [1:0] fb,
                              input logic asel, input logic bsel, input logic [31:0] rd1,
                              input logic [31:0] rd2, input logic [31:0] resW, input logic [31:0] pc,
                              input logic [31:0] imm, input logic [31:0] expAlu,
                              input logic [31:0] expData);
    vec_t v;
    v.op = op; v.fa = fa; v.fb = fb; v.asel = asel; v.bsel = bsel;
    v.rd1 = rd1; v.rd2 = rd2; v.resW = resW; v.pc = pc; v.imm = imm;
    v.expAlu = expAlu; v.expData = expData;
    return v;
  endfunction

  task automatic drive(input logic [2:0] op, input logic [1:0] fa, input logic [1:0] fb,
                       input logic asel, input logic bsel, input logic [31:0] rd1,
                       input logic [31:0] rd2, input logic [31:0] resW, input logic [31:0] pc,
                       input logic [31:0] imm);
    ALUselE = op; forwardAE = fa; forwardBE = fb; aselE = asel; bselE = bsel;
    rd1E = rd1; rd2E = rd2; resultW = resW; pcE = pc; imm_exE = imm;
  endtask

  initial begin
    // Table entries run back-to-back; forward-from-MEM entries depend on the
    // result of the entry before them.
    vecs[0]  = mk(3'b001, 2'b00, 2'b00, 0, 0, 32'd50, 32'd30, 32'd0, 32'd0, 32'd0, 32'd20, 32'd30);
    vecs[1]  = mk(3'b010, 2'b00, 2'b00, 0, 0, 32'hF0, 32'h0F, 32'd0, 32'd0, 32'd0, 32'h0, 32'h0F);
    vecs[2]  = mk(3'b011, 2'b00, 2'b00, 0, 0, 32'hF0, 32'h0F, 32'd0, 32'd0, 32'd0, 32'hFF, 32'h0F);
    vecs[3]  = mk(3'b100, 2'b00, 2'b00, 0, 0, 32'hAA, 32'h55, 32'd0, 32'd0, 32'd0, 32'hFF, 32'h55);
    vecs[4]  = mk(3'b001, 2'b00, 2'b00, 0, 0, 32'd0, 32'd1, 32'd0, 32'd0, 32'd0, 32'hFFFFFFFF, 32'd1);
    vecs[5]  = mk(3'b101, 2'b00, 2'b00, 0, 0, 32'd1, 32'd33, 32'd0, 32'd0, 32'd0, 32'd2, 32'd33);
    vecs[6]  = mk(3'b111, 2'b00, 2'b00, 0, 0, 32'hFFFFFFFF, 32'd5, 32'd0, 32'd0, 32'd0, 32'd1, 32'd5);
    vecs[7]  = mk(3'b111, 2'b00, 2'b00, 0, 0, 32'd5, 32'hFFFFFFFF, 32'd0, 32'd0, 32'd0, 32'd0, 32'hFFFFFFFF);
    vecs[8]  = mk(3'b000, 2'b00, 2'b00, 0, 0, 32'd10, 32'd20, 32'd0, 32'd0, 32'd0, 32'd30, 32'd20);
    vecs[9]  = mk(3'b000, 2'b10, 2'b01, 0, 0, 32'd0, 32'd99, 32'd7, 32'd0, 32'd0, 32'd37, 32'd7);
    vecs[10] = mk(3'b000, 2'b00, 2'b00, 1, 1, 32'd77, 32'h55, 32'd0, 32'h100, 32'h10, 32'h110, 32'h55);
    vecs[11] = mk(3'b000, 2'b11, 2'b11, 0, 0, 32'd5, 32'd3, 32'd100, 32'd0, 32'd0, 32'd8, 32'd3);
    vecs[12] = mk(3'b110, 2'b00, 2'b00, 0, 0, 32'h80000000, 32'd4, 32'd0, 32'd0, 32'd0, 32'h08000000, 32'd4);
    vecs[13] = mk(3'b001, 2'b10, 2'b10, 0, 1, 32'd1, 32'd2, 32'd0, 32'd0, 32'd8, 32'h07FFFFF8, 32'h08000000);
    vecs[14] = mk(3'b000, 2'b00, 2'b00, 0, 1, 32'hFFFFFFFF, 32'd6, 32'd0, 32'd0, 32'd2, 32'd1, 32'd6);

    rst_n = 1'b1;
    regwriteE = 1'b1; memrwE = 1'b1; wbselE = 2'b11; pc4E = 32'h1234; rdE = 5'd9;
    rs1E = 5'd3; rs2E = 5'd4;
    drive(3'b000, 2'b00, 2'b00, 0, 0, 32'd11, 32'd22, 32'd0, 32'd0, 32'd0);

    @(posedge clk); #1;
    chkAllZero("rst_edge");
    #3;
    chkAllZero("rst_mid");

    // Release between edges; first capture is the next rising edge.
    rst_n = 1'b0;
    regwriteE = 1'b1; memrwE = 1'b0; wbselE = 2'b01; pc4E = 32'd4; rdE = 5'd1;
    drive(3'b000, 2'b00, 2'b00, 0, 0, 32'd10, 32'd20, 32'd0, 32'd0, 32'd0);
    @(posedge clk); #1;
    chk("first.ALUresM", ALUresM, 32'd30);
    chk("first.rdM", {27'd0, rdM}, 32'd1);
    chk("first.regwriteM", {31'd0, regwriteM}, 32'd1);
    chk("first.memrwM", {31'd0, memrwM}, 32'd0);
    chk("first.wbselM", {30'd0, wbselM}, 32'd1);
    chk("first.pc4M", pc4M, 32'd4);
    chk("first.data_writeM", data_writeM, 32'd20);

    for (int i = 0; i < 15; i++) begin
      logic [31:0] pc4v;
      logic [4:0]  rdv;
      logic [1:0]  wbv;
      pc4v = 32'h1000 + 32'(4 * i);
      rdv = 5'(i + 2);
      wbv = 2'(i);
      regwriteE = ~wbv[0]; memrwE = wbv[0]; wbselE = wbv; pc4E = pc4v; rdE = rdv;
      drive(vecs[i].op, vecs[i].fa, vecs[i].fb, vecs[i].asel, vecs[i].bsel, vecs[i].rd1,
            vecs[i].rd2, vecs[i].resW, vecs[i].pc, vecs[i].imm);
      @(posedge clk); #1;
      chk($sformatf("vec%0d.ALUresM", i), ALUresM, vecs[i].expAlu);
      chk($sformatf("vec%0d.data_writeM", i), data_writeM, vecs[i].expData);
      chk($sformatf("vec%0d.ctrl", i), {22'd0, regwriteM, memrwM, wbselM, rdM},
          {22'd0, ~wbv[0], wbv[0], wbv, rdv});
      chk($sformatf("vec%0d.pc4M", i), pc4M, pc4v);
    end

    // Async reset mid-stream: outputs hold the last result (1) until now.
    #2;
    rst_n = 1'b1;
    #1;
    chkAllZero("midrst_async");
    @(posedge clk); #1;
    chkAllZero("midrst_held1");
    @(posedge clk); #1;
    chkAllZero("midrst_held2");

    // After release, forwarding from MEM sees the cleared register.
    rst_n = 1'b0;
    regwriteE = 1'b1; memrwE = 1'b1; wbselE = 2'b10; pc4E = 32'h40; rdE = 5'd31;
    drive(3'b000, 2'b10, 2'b00, 0, 1, 32'd123, 32'd9, 32'd0, 32'd0, 32'd5);
    @(posedge clk); #1;
    chk("post.ALUresM", ALUresM, 32'd5);
    chk("post.data_writeM", data_writeM, 32'd9);
    chk("post.ctrl", {22'd0, regwriteM, memrwM, wbselM, rdM}, {22'd0, 1'b1, 1'b1, 2'b10, 5'd31});
    chk("post.pc4M", pc4M, 32'h40);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
